// File: rtl/mul_float_axis_pipe_if.sv
// AXI-Stream beat bundle shared by the two operand ports and the result port
// of the floating-point multiplier.
//   tvalid  producer has a beat
//   tready  consumer takes the beat on this edge
//   tdata   {sign, exponent, mantissa}, W bits
//   tlast   frame end marker
// master drives valid/data/last, slave drives ready.
interface mul_float_axis_pipe_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/mul_float_axis_pipe.sv
// Three-stage pipelined floating-point multiplier with AXI-Stream ports.
// Generic {sign, EXP_W exponent, MAN_W mantissa} format, round-to-nearest-even,
// inputs denormal-as-zero, outputs flush-to-zero, canonical quiet NaN.
// Ports:
//   aclk           clock, rising edge
//   areset         synchronous reset, active-high; drops every in-flight beat
//   s_axis_a       operand A stream (slave)
//   s_axis_b       operand B stream (slave); joined with A, both tready equal
//   m_axis_result  product stream (master), tlast merged per TLAST_MODE
//                  (0=A, 1=B, 2=A|B, 3=A&B)
module mul_float_axis_pipe #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 23,
  parameter int TLAST_MODE = 0
) (
  input  logic                 aclk,
  input  logic                 areset,
  mul_float_axis_pipe_if.slave  s_axis_a,
  mul_float_axis_pipe_if.slave  s_axis_b,
  mul_float_axis_pipe_if.master m_axis_result
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_C     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX_C  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_C      = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO_C = EW'(0);

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  logic               ce_s, accept_s;
  logic               a_sign_s, b_sign_s;
  logic [EXP_W-1:0]   a_exp_s, b_exp_s;
  logic [MAN_W-1:0]   a_man_s, b_man_s;
  logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  cls_t               cls_s;
  logic               last_s;
  logic signed [EW-1:0] exp_sum_s;
  logic [PW-1:0]      prod_s;

  logic               s1_valid_r, s1_last_r, s1_sign_r;
  cls_t               s1_cls_r;
  logic signed [EW-1:0] s1_exp_r;
  logic [PW-1:0]      s1_prod_r;

  logic [MAN_W-1:0]   norm_man_s;
  logic               norm_guard_s, norm_sticky_s;
  logic signed [EW-1:0] norm_exp_s;

  logic               s2_valid_r, s2_last_r, s2_sign_r, s2_guard_r, s2_sticky_r;
  cls_t               s2_cls_r;
  logic signed [EW-1:0] s2_exp_r;
  logic [MAN_W-1:0]   s2_man_r;

  logic               round_up_s;
  logic [MAN_W:0]     man_rnd_s;
  logic signed [EW-1:0] exp_rnd_s;
  logic [W-1:0]       res_s;

  logic               s3_valid_r, s3_last_r;
  logic [W-1:0]       s3_data_r;

  // A stalled output freezes the whole pipe; a beat joins only with both operands present.
  assign ce_s     = ~s3_valid_r | m_axis_result.tready;
  assign accept_s = s_axis_a.tvalid & s_axis_b.tvalid & ce_s;
  assign s_axis_a.tready = accept_s;
  assign s_axis_b.tready = accept_s;

  assign m_axis_result.tvalid = s3_valid_r;
  assign m_axis_result.tdata  = s3_data_r;
  assign m_axis_result.tlast  = s3_last_r;

  // Stage 1 logic: unpack, classify, sign, biased exponent sum, mantissa product.
  always_comb begin
    a_sign_s = s_axis_a.tdata[W-1];
    b_sign_s = s_axis_b.tdata[W-1];
    a_exp_s  = s_axis_a.tdata[W-2:MAN_W];
    b_exp_s  = s_axis_b.tdata[W-2:MAN_W];
    a_man_s  = s_axis_a.tdata[MAN_W-1:0];
    b_man_s  = s_axis_b.tdata[MAN_W-1:0];
    a_nan_s  = (&a_exp_s) & (|a_man_s);
    b_nan_s  = (&b_exp_s) & (|b_man_s);
    a_inf_s  = (&a_exp_s) & ~(|a_man_s);
    b_inf_s  = (&b_exp_s) & ~(|b_man_s);
    // Subnormals are treated as zero, so only the exponent matters here.
    a_zero_s = ~(|a_exp_s);
    b_zero_s = ~(|b_exp_s);
    if (a_nan_s | b_nan_s) begin
      cls_s = CLS_NAN;
    end else if ((a_inf_s & b_zero_s) | (b_inf_s & a_zero_s)) begin
      cls_s = CLS_NAN;
    end else if (a_inf_s | b_inf_s) begin
      cls_s = CLS_INF;
    end else if (a_zero_s | b_zero_s) begin
      cls_s = CLS_ZERO;
    end else begin
      cls_s = CLS_NORM;
    end
    case (TLAST_MODE)
      0:       last_s = s_axis_a.tlast;
      1:       last_s = s_axis_b.tlast;
      2:       last_s = s_axis_a.tlast | s_axis_b.tlast;
      default: last_s = s_axis_a.tlast & s_axis_b.tlast;
    endcase
    exp_sum_s = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - BIAS_C;
    prod_s    = PW'({1'b1, a_man_s}) * PW'({1'b1, b_man_s});
  end

  // Stage 1 register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_cls_r   <= CLS_ZERO;
      s1_exp_r   <= EXP_ZERO_C;
      s1_prod_r  <= '0;
    end else if (ce_s) begin
      s1_valid_r <= accept_s;
      s1_last_r  <= last_s;
      s1_sign_r  <= a_sign_s ^ b_sign_s;
      s1_cls_r   <= cls_s;
      s1_exp_r   <= exp_sum_s;
      s1_prod_r  <= prod_s;
    end
  end

  // Stage 2 logic: product of two [1,2) values lies in [1,4); renormalise and
  // collapse everything below the kept mantissa into guard and sticky bits.
  always_comb begin
    if (s1_prod_r[PW-1]) begin
      norm_man_s    = s1_prod_r[PW-2 -: MAN_W];
      norm_guard_s  = s1_prod_r[MAN_W];
      norm_sticky_s = |s1_prod_r[MAN_W-1:0];
      norm_exp_s    = s1_exp_r + ONE_C;
    end else begin
      norm_man_s    = s1_prod_r[PW-3 -: MAN_W];
      norm_guard_s  = s1_prod_r[MAN_W-1];
      norm_sticky_s = |s1_prod_r[MAN_W-2:0];
      norm_exp_s    = s1_exp_r;
    end
  end

  // Stage 2 register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s2_valid_r  <= 1'b0;
      s2_last_r   <= 1'b0;
      s2_sign_r   <= 1'b0;
      s2_cls_r    <= CLS_ZERO;
      s2_exp_r    <= EXP_ZERO_C;
      s2_man_r    <= '0;
      s2_guard_r  <= 1'b0;
      s2_sticky_r <= 1'b0;
    end else if (ce_s) begin
      s2_valid_r  <= s1_valid_r;
      s2_last_r   <= s1_last_r;
      s2_sign_r   <= s1_sign_r;
      s2_cls_r    <= s1_cls_r;
      s2_exp_r    <= norm_exp_s;
      s2_man_r    <= norm_man_s;
      s2_guard_r  <= norm_guard_s;
      s2_sticky_r <= norm_sticky_s;
    end
  end

  // Stage 3 logic: round to nearest even, range check, pack.
  always_comb begin
    round_up_s = s2_guard_r & (s2_sticky_r | s2_man_r[0]);
    man_rnd_s  = {1'b0, s2_man_r} + {{MAN_W{1'b0}}, round_up_s};
    // A carry out of the mantissa leaves the stored bits at zero and bumps the exponent.
    exp_rnd_s  = man_rnd_s[MAN_W] ? (s2_exp_r + ONE_C) : s2_exp_r;
    case (s2_cls_r)
      CLS_NAN:  res_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      CLS_INF:  res_s = {s2_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res_s = {s2_sign_r, {(W-1){1'b0}}};
      default: begin
        if (s2_exp_r >= EXP_MAX_C) begin
          res_s = {s2_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_exp_r <= EXP_ZERO_C) begin
          res_s = {s2_sign_r, {(W-1){1'b0}}};
        end else if (exp_rnd_s >= EXP_MAX_C) begin
          res_s = {s2_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
          res_s = {s2_sign_r, exp_rnd_s[EXP_W-1:0], man_rnd_s[MAN_W-1:0]};
        end
      end
    endcase
  end

  // Stage 3 register doubles as the output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s3_valid_r <= 1'b0;
      s3_last_r  <= 1'b0;
      s3_data_r  <= '0;
    end else if (ce_s) begin
      s3_valid_r <= s2_valid_r;
      s3_last_r  <= s2_last_r;
      s3_data_r  <= res_s;
    end
  end
endmodule

// File: tb/tb_mul_float_axis_pipe.sv
// Self-checking bench for mul_float_axis_pipe (binary32 defaults).
// Stimulus goes in at the falling edge; each expected product is queued when
// the bench sees the operand handshake and popped when the result handshakes.
module tb_mul_float_axis_pipe;
  logic aclk;
  logic areset;

  mul_float_axis_pipe_if #(.W(32)) ia ();
  mul_float_axis_pipe_if #(.W(32)) ib ();
  mul_float_axis_pipe_if #(.W(32)) mr ();

  mul_float_axis_pipe #(.EXP_W(8), .MAN_W(23), .TLAST_MODE(0)) dut (
    .aclk(aclk), .areset(areset), .s_axis_a(ia), .s_axis_b(ib), .m_axis_result(mr)
  );

  // Copies for the other tlast merge modes, fed the same operands, never stalled.
  for (genvar g = 1; g < 4; g++) begin : g_mode
    mul_float_axis_pipe_if #(.W(32)) xa ();
    mul_float_axis_pipe_if #(.W(32)) xb ();
    mul_float_axis_pipe_if #(.W(32)) xr ();
    assign xa.tvalid = ia.tvalid;
    assign xa.tdata  = ia.tdata;
    assign xa.tlast  = ia.tlast;
    assign xb.tvalid = ib.tvalid;
    assign xb.tdata  = ib.tdata;
    assign xb.tlast  = ib.tlast;
    assign xr.tready = 1'b1;
    mul_float_axis_pipe #(.EXP_W(8), .MAN_W(23), .TLAST_MODE(g)) u_dut (
      .aclk(aclk), .areset(areset), .s_axis_a(xa), .s_axis_b(xb), .m_axis_result(xr)
    );
  end

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          check_cnt_s, error_cnt_s;
  logic [32:0] exp_q[$];
  logic        acc_s, out_hs_s, rand_rdy_s;
  int          tick_n_s, first_out_s, last_out_s, in_cnt_s, out_cnt_s, last_wait_s;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
    check_cnt_s++;
    if (obs !== req) begin
      error_cnt_s++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  // Reference binary32 product: exact integer product, remainder-based RNE.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    logic s, an, bn, ai, bi, az, bz;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = 64'(a[22:0]);   mb = 64'(b[22:0]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (ma != 0); bn = (eb == 255) && (mb != 0);
    ai = (ea == 255) && (ma == 0); bi = (eb == 255) && (mb == 0);
    az = (ea == 0);                bz = (eb == 0);
    if (an || bn) return 32'h7FC00000;
    if ((ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'h0};
    if (az || bz) return {s, 31'h0};
    ma = ma | 64'h800000;
    mb = mb | 64'h800000;
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'h1 << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'h1 << (sh - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 64'h1;
    if (q == 64'h1000000) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  // One clock: caller has set inputs at the falling edge; sample mid-cycle, then advance.
  task automatic tick();
    logic        hold_v, rst_edge_v, join_v;
    logic [32:0] held_v, exp_v;
    if (rand_rdy_s) mr.tready = 1'($urandom_range(0, 1));
    #1;
    join_v = ia.tvalid & ib.tvalid & (~mr.tvalid | mr.tready);
    check_eq("tready_a", 64'(ia.tready), 64'(join_v));
    check_eq("tready_b", 64'(ib.tready), 64'(join_v));
    acc_s = ia.tready;
    if (acc_s) begin
      exp_q.push_back({ia.tlast, ref_mul(ia.tdata, ib.tdata)});
      in_cnt_s++;
    end
    out_hs_s = mr.tvalid & mr.tready;
    if (out_hs_s) begin
      check_eq("out_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check_eq("result_data", 64'(mr.tdata), 64'(exp_v[31:0]));
        check_eq("result_last", 64'(mr.tlast), 64'(exp_v[32]));
      end
      out_cnt_s++;
      if (first_out_s < 0) first_out_s = tick_n_s;
      last_out_s = tick_n_s;
    end
    hold_v = mr.tvalid & ~mr.tready;
    held_v = {mr.tlast, mr.tdata};
    @(posedge aclk);
    rst_edge_v = areset;
    @(negedge aclk);
    tick_n_s++;
    if (hold_v && !rst_edge_v) begin
      check_eq("hold_valid", 64'(mr.tvalid), 64'(1));
      check_eq("hold_data", 64'({mr.tlast, mr.tdata}), 64'(held_v));
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic la, input logic lb);
    int n;
    n = 0;
    ia.tvalid = 1'b1; ia.tdata = a; ia.tlast = la;
    ib.tvalid = 1'b1; ib.tdata = b; ib.tlast = lb;
    do begin
      tick();
      n++;
    end while (!acc_s && n < 200);
    check_eq("send_accept", 64'(acc_s), 64'(1));
    ia.tvalid = 1'b0;
    ib.tvalid = 1'b0;
    last_wait_s = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy_s = 1'b0;
    ia.tvalid = 1'b0;
    ib.tvalid = 1'b0;
    mr.tready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int lat, in0, out0;
    check_cnt_s = 0; error_cnt_s = 0; tick_n_s = 0; first_out_s = -1; last_out_s = -1;
    in_cnt_s = 0; out_cnt_s = 0; rand_rdy_s = 1'b0; acc_s = 1'b0; out_hs_s = 1'b0;
    ia.tvalid = 1'b0; ia.tdata = 32'h0; ia.tlast = 1'b0;
    ib.tvalid = 1'b0; ib.tdata = 32'h0; ib.tlast = 1'b0;
    mr.tready = 1'b1;
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check_eq("reset_tvalid", 64'(mr.tvalid), 64'(0));
    check_eq("reset_tdata", 64'(mr.tdata), 64'(0));
    check_eq("reset_tlast", 64'(mr.tlast), 64'(0));
    areset = 1'b0;

    // Basic product and latency counted in edges from the accept edge.
    send(32'h3FC00000, 32'h40000000, 1'b0, 1'b0);
    lat = 1;
    while (!mr.tvalid && lat < 10) begin
      tick();
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(3));
    check_eq("basic_value", 64'(mr.tdata), 64'(32'h40400000));
    drain();

    // Eight back-to-back beats in, eight consecutive results out.
    first_out_s = -1; out0 = out_cnt_s;
    for (int i = 0; i < 8; i++) begin
      send(32'hBFC00000, 32'h40000000, 1'b0, 1'b0);
      check_eq("b2b_accept_wait", 64'(last_wait_s), 64'(1));
    end
    drain();
    check_eq("b2b_count", 64'(out_cnt_s - out0), 64'(8));
    check_eq("b2b_span", 64'(last_out_s - first_out_s), 64'(7));

    // Rounding and special operands.
    send(32'h3F800001, 32'h3FC00000, 1'b0, 1'b0);
    send(32'h3F800001, 32'h3F800001, 1'b0, 1'b0);
    send(32'h7F000000, 32'h40000000, 1'b0, 1'b0);
    send(32'h00800000, 32'h3F000000, 1'b0, 1'b0);
    send(32'h7F800000, 32'h00000000, 1'b0, 1'b0);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 1'b0);
    send(32'hFF800000, 32'h40000000, 1'b0, 1'b0);
    send(32'h3FFFFFFF, 32'h3F800001, 1'b0, 1'b0);
    drain();
    check_eq("ref_rne_tie", 64'(ref_mul(32'h3F800001, 32'h3FC00000)), 64'(32'h3FC00002));

    // Lone A waits until B shows up.
    ia.tvalid = 1'b1; ia.tdata = 32'h40400000; ia.tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("join_wait", 64'(acc_s), 64'(0));
    end
    send(32'h40400000, 32'h40400000, 1'b0, 1'b0);
    drain();

    // Random operands under random backpressure.
    in0 = in_cnt_s; out0 = out_cnt_s;
    rand_rdy_s = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    check_eq("rand_in_count", 64'(in_cnt_s - in0), 64'(100));
    check_eq("rand_out_count", 64'(out_cnt_s - out0), 64'(100));

    // tlast merge across all four modes.
    send(32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    lat = 1;
    while (!mr.tvalid && lat < 10) begin
      tick();
      lat++;
    end
    check_eq("tlast_m0", 64'({mr.tvalid, mr.tlast}), 64'(2'b11));
    check_eq("tlast_m1", 64'({g_mode[1].xr.tvalid, g_mode[1].xr.tlast}), 64'(2'b10));
    check_eq("tlast_m2", 64'({g_mode[2].xr.tvalid, g_mode[2].xr.tlast}), 64'(2'b11));
    check_eq("tlast_m3", 64'({g_mode[3].xr.tvalid, g_mode[3].xr.tlast}), 64'(2'b10));
    drain();

    // Reset with three beats in flight and the output stalled.
    mr.tready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h40000000, 32'h40000000, 1'b0, 1'b0);
    check_eq("flight_valid", 64'(mr.tvalid), 64'(1));
    areset = 1'b1;
    tick();
    check_eq("mid_reset_tvalid", 64'(mr.tvalid), 64'(0));
    check_eq("mid_reset_tdata", 64'(mr.tdata), 64'(0));
    exp_q.delete();
    areset = 1'b0;
    mr.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("post_reset_idle", 64'(mr.tvalid), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt_s, error_cnt_s);
    $finish;
  end
endmodule
